// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int MAX_WR    = 2;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xdata_t;

    // Highest-indexed requesting write port wins.
    function automatic logic [MAX_WR-1:0] onehot_hi_prio(input logic [MAX_WR-1:0] req);
        logic [MAX_WR-1:0] g;
        g = '0;
        for (int k = 0; k < MAX_WR; k++)
            if (req[k]) g = MAX_WR'(1) << k;
        return g;
    endfunction
endpackage

// File: rtl/regfile_mp_rf_scoreboard.sv
// Busy-bit scoreboard: reserve sets, writeback clears, reserve wins a tie.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = $clog2(NREGS),
    parameter int NUM_WR = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WR-1:0]    i_wb_en,
    input  logic [NUM_WR*AW-1:0] i_wb_addr,
    input  logic                 i_rsv_en,
    input  logic [AW-1:0]        i_rsv_addr,
    output logic [NREGS-1:0]     o_busy,
    output logic [NREGS-1:0]     o_fwd_clr,
    output logic [AW:0]          o_busy_cnt
);
    logic [NREGS-1:1] r_busy;
    logic [AW:0]      r_cnt;
    logic [NREGS-1:0] w_set, w_clr, w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_rsv_en) w_set[i_rsv_addr] = 1'b1;
        for (int k = 0; k < NUM_WR; k++)
            if (i_wb_en[k]) w_clr[i_wb_addr[k*AW +: AW]] = 1'b1;
        w_set[0] = 1'b0;
        w_busy_nxt = (o_busy & ~w_clr) | w_set;
        w_cnt_nxt = '0;
        for (int i = 1; i < NREGS; i++)
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt[NREGS-1:1];
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_busy     = {r_busy, 1'b0};
    assign o_fwd_clr  = w_clr & ~w_set;
    assign o_busy_cnt = r_cnt;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = $clog2(NREGS),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_WR-1:0]      wb_en,
    input  logic [NUM_WR*AW-1:0]   wb_addr,
    input  logic [NUM_WR*XLEN-1:0] wb_data,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic [AW:0]            busy_cnt
);
    logic [XLEN-1:0]  r_regs [1:NREGS-1];
    logic [NREGS-1:0] w_busy, w_fwd_clr;

    // Later ports overwrite earlier ones, giving port 1 priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++)
                for (int k = 0; k < NUM_WR; k++)
                    if (wb_en[k] && wb_addr[k*AW +: AW] == AW'(i))
                        r_regs[i] <= wb_data[k*XLEN +: XLEN];
        end
    end

    rf_scoreboard #(.NREGS(NREGS), .AW(AW), .NUM_WR(NUM_WR)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_wb_en    (wb_en),
        .i_wb_addr  (wb_addr),
        .i_rsv_en   (rsv_en),
        .i_rsv_addr (rsv_addr),
        .o_busy     (w_busy),
        .o_fwd_clr  (w_fwd_clr),
        .o_busy_cnt (busy_cnt)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic [MAX_WR-1:0] w_hit, w_win;
        logic [XLEN-1:0]   w_val;

        assign w_addr = rd_addr[p*AW +: AW];

        always_comb begin
            w_val = '0;
            w_hit = '0;
            for (int i = 1; i < NREGS; i++)
                if (w_addr == AW'(i)) w_val = r_regs[i];
            for (int k = 0; k < NUM_WR; k++)
                w_hit[k] = wb_en[k] && (wb_addr[k*AW +: AW] == w_addr) && (w_addr != '0);
            w_win = onehot_hi_prio(w_hit);
            if (BYPASS != 0)
                for (int k = 0; k < NUM_WR; k++)
                    if (w_win[k]) w_val = wb_data[k*XLEN +: XLEN];
            // Outputs are held at zero while reset is asserted, bypass included.
            if (!rst) w_val = '0;
        end

        assign rd_data[p*XLEN +: XLEN] = w_val;
        assign rd_busy[p] = rst && w_busy[w_addr] && !((BYPASS != 0) && w_fwd_clr[w_addr]);
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the CPU pipeline, successor to the single-write, two-read register file.
- Supports NUM_RD combinational read ports and NUM_WR synchronous write ports, with optional write-to-read bypass.
- Adds a per-register busy scoreboard: the decode stage reserves a destination, writeback releases it, and read ports report pending hazards.
- Register 0 is hardwired to zero, is never stored and is never busy.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width (derived; do not override).
- NUM_RD, 2, number of read ports, 1..4.
- NUM_WR, 1, number of write ports, 1..2.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the matching read port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- wb_en  in  NUM_WR  per-port write enable.
- wb_addr  in  NUM_WR*AW  write addresses; port k uses slice [k*AW +: AW].
- wb_data  in  NUM_WR*XLEN  write data, packed the same way.
- rd_addr  in  NUM_RD*AW  read addresses, packed.
- rd_data  out  NUM_RD*XLEN  read data, packed.
- rd_busy  out  NUM_RD  per-port flag: the addressed register has a pending producer.
- rsv_en  in  1  reserve (mark busy) a destination register.
- rsv_addr  in  AW  register to reserve.
- busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers 1..NREGS-1 clear to 0 and all busy bits clear;
  - rd_data reads 0, rd_busy is 0 and busy_cnt is 0 for the whole time reset is held.
- Storage:
  - regs[1..NREGS-1] hold XLEN bits each;
  - a write with wb_en[k]=1 and wb_addr!=0 updates regs on the rising edge; writes to address 0 are dropped.
- Write conflict: when two write ports target the same address in one cycle, the higher port index wins (port 1 over port 0).
- Read is combinational, zero latency:
  - address 0 returns 0;
  - otherwise the stored value is returned;
  - if BYPASS=1 and an enabled write port targets the same non-zero address in the same cycle, the write data is returned instead, applying the same priority rule;
  - if BYPASS=0 the old value is returned until the next cycle.
- Scoreboard:
  - one busy bit per register 1..NREGS-1;
  - rsv_en=1 with rsv_addr!=0 sets busy[rsv_addr] on the rising edge;
  - an enabled write on any port clears busy[wb_addr] on the rising edge;
  - reserve and clear of the same address in the same cycle leaves the bit SET, because the new producer supersedes the retiring one;
  - reserving an already-busy register keeps it set; no error is raised and no counter is kept;
  - a write to a non-busy register is legal and leaves the bit at 0.
- rd_busy[p]:
  - equals busy[rd_addr[p]] from current state, combinationally;
  - is 0 for address 0;
  - if BYPASS=1, a same-cycle clearing write to that address forces it to 0, unless a same-cycle reserve targets the same address.
- busy_cnt:
  - registered population count of the busy bits, reflecting state after the last edge;
  - maximum value is NREGS-1.
- Reset asserted mid-operation clears everything immediately; in-flight reservations are lost. The pipeline flush is the owner's responsibility.
- No X propagation: out-of-range addresses cannot occur because address width equals AW.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN_DEF and NREGS_DEF constants;
  - typedef reg_addr_t (logic [AW-1:0]) and typedef xdata_t (logic [XLEN-1:0]);
  - function onehot_hi_prio, which selects the winning write port.
- One natural sub-module, rf_scoreboard: the busy bits, reserve/clear priority and busy_cnt. Storage and read muxing stay in regfile_mp.

Test Plan:
- Reset then read: hold rst=0, then release; read x5 and x31 -> rd_data=0, rd_busy=0, busy_cnt=0.
- Write then read: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF. With BYPASS=1, a same-cycle read of x5 returns 0xDEADBEEF; with BYPASS=0 it returns 0, and returns 0xDEADBEEF one cycle later.
- x0 immunity: write 0x12345678 to x0, then read x0 -> 0; rsv_addr=0 -> busy_cnt stays 0.
- Dual-write conflict (NUM_WR=2): both ports write x7, port0=0x11 and port1=0x22 -> x7=0x22 next cycle; same-cycle bypass read also returns 0x22.
- Scoreboard:
  - reserve x3, next cycle: rd_busy=1 on x3, busy_cnt=1;
  - write x3 together with a same-cycle reserve of x3 -> x3 still busy, value updated;
  - write x3 alone -> busy clears and busy_cnt=0.
- Async reset mid-run: reserve x1, x2, x4 and write x1=0xAA, then drop rst between clock edges -> busy_cnt, rd_busy and rd_data all read 0 immediately, without waiting for a clock edge.
